// File: rtl/riscv_pkg.sv
// Shared load/store definitions: access-size encodings, FSM states, bus widths
// and the request-side formatting helpers (byte enables, store lane replication).
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_e;

  // Unsigned variants only exist for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic f3_aligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b01:   return !off[0];
      2'b10:   return off == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] lsu_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return BE_W'(1) << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lsu_wdata(input logic [1:0] sz, input logic [XLEN-1:0] wd);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-bus request/response channel between the load/store unit and memory.
interface load_store_unit_if;
  import riscv_pkg::*;

  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [BE_W-1:0] bus_be;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_gnt;
  logic            bus_rvalid;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Load formatting: pick the addressed byte/half lane and sign- or zero-extend.
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (off_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    half_lane = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    data_o = {{16{half_lane[15]}}, half_lane};
      F3_W:    data_o = rdata_i;
      F3_BU:   data_o = {24'd0, byte_lane};
      F3_HU:   data_o = {16'd0, half_lane};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one bus transaction per request, stalling the core
// until DONE; bus fields held stable until gnt, aborts with err after TIMEOUT_CYC.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             mem_read,
  input  logic             mem_w,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  write_data,
  output logic [XLEN-1:0]  read_data,
  output logic             stall,
  output logic             err,
  load_store_unit_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  lsu_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            bus_req_q, bus_we_q;
  logic [XLEN-1:0] bus_addr_q, bus_wdata_q, read_data_q;
  logic [BE_W-1:0] bus_be_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic            err_q;

  logic            req, legal, timeout;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    req     = mem_read | mem_w;
    legal   = !(mem_read && mem_w) && f3_legal(funct3, mem_w) && f3_aligned(funct3[1:0], addr[1:0]);
    stall   = srst_n && req && legal && (state_q != LSU_DONE);
    timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  end

  load_align u_load_align (
    .rdata_i  (bus.bus_rdata),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_o   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q     <= LSU_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      read_data_q <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (req && legal) begin
            state_q     <= LSU_REQ;
            cnt_q       <= '0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_w;
            bus_addr_q  <= {addr[XLEN-1:2], 2'b00};
            bus_be_q    <= lsu_be(funct3[1:0], addr[1:0]);
            bus_wdata_q <= mem_w ? lsu_wdata(funct3[1:0], write_data) : '0;
            funct3_q    <= funct3;
            off_q       <= addr[1:0];
            read_data_q <= '0;
          end else if (req) begin
            err_q       <= 1'b1;
            read_data_q <= '0;
          end
        end
        LSU_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.bus_gnt) begin
            bus_req_q <= 1'b0;
            state_q   <= bus_we_q ? LSU_DONE : LSU_WAIT;
          end else if (timeout) begin
            bus_req_q   <= 1'b0;
            err_q       <= 1'b1;
            read_data_q <= '0;
            state_q     <= LSU_DONE;
          end
        end
        LSU_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.bus_rvalid) begin
            read_data_q <= ld_data;
            state_q     <= LSU_DONE;
          end else if (timeout) begin
            err_q       <= 1'b1;
            read_data_q <= '0;
            state_q     <= LSU_DONE;
          end
        end
        LSU_DONE: state_q <= LSU_IDLE;
        default:  state_q <= LSU_IDLE;
      endcase
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign read_data     = read_data_q;
  assign err           = err_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the single-cycle datapath and a handshaked data bus. It takes the ALU-computed address, store data, access size and load/store strobes, and runs one bus transaction with alignment checking, byte-enable generation and load sign/zero-extension. It holds the core with `stall` until the access completes, then returns formatted `read_data` to the result mux.

## Interface
- `TIMEOUT_CYC`, 16: maximum cycles waiting in REQ plus WAIT before the access aborts with an error.
- `clk` in 1: clock. Single clock domain.
- `srst_n` in 1: reset. Synchronous, active-low.
- `mem_read` in 1: load request from the controller. Level, held until `stall` is low.
- `mem_w` in 1: store request. Level, held until `stall` is low.
- `funct3` in 3: access size and sign. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr` in 32: byte address (ALU result).
- `write_data` in 32: store data (register file RD2).
- `read_data` out 32: formatted load result. Valid in the DONE cycle.
- `stall` out 1: freezes PC and register-file write while an access is in flight.
- `err` out 1: one-cycle pulse on a misaligned access, illegal request, or timeout.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32 (word-aligned), `bus_be` out 4, `bus_wdata` out 32: request channel.
- `bus_gnt` in 1: request accepted.
- `bus_rvalid` in 1, `bus_rdata` in 32: load response. Arrives no earlier than the cycle after `bus_gnt`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**, with `mem_read` or `mem_w` asserted:
  - Legal request: register the bus fields and go to REQ.
  - Illegal request: no bus access; `err` pulses next cycle; `read_data`=0; stay IDLE.
    - Misaligned: half access with `addr[0]`=1, or word access with `addr[1:0]`≠0.
    - Reserved `funct3`.
    - `mem_read` and `mem_w` both high.
- **REQ**:
  - `bus_req`=1, and all bus fields stay stable until `bus_gnt`.
  - On `gnt`, a store goes to DONE and a load goes to WAIT.
  - `bus_rvalid` is ignored in REQ.
- **WAIT**: on `bus_rvalid`, capture the formatted `bus_rdata` into `read_data` and go to DONE.
- **DONE**: one cycle with `stall`=0 so the core retires the instruction, then always go to IDLE. Requests seen in DONE are not re-accepted.
- **Timeout**:
  - The cycle counter clears on entering REQ and counts in REQ and WAIT.
  - When it reaches `TIMEOUT_CYC`: drop `bus_req`, pulse `err`, set `read_data`=0, go to DONE.
  - A later `bus_rvalid` is ignored.
- **Byte enables**:
  - Byte: `bus_be` = 1<<`addr[1:0]`.
  - Half: 0011 or 1100, selected by `addr[1]`.
  - Word: 1111.
- **Store data**:
  - Byte: `{4{write_data[7:0]}}`.
  - Half: `{2{write_data[15:0]}}`.
  - Word: `write_data` unchanged.
- **Load data**:
  - Select the lane by `addr[1:0]`.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes through.
- `bus_addr` = {`addr[31:2]`, 2'b00}.
- `bus_rvalid` is ignored in IDLE and DONE.

## Timing
- Reset values (next edge with `srst_n`=0):
  - State IDLE, counter 0.
  - `bus_req`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata` = 0.
  - `read_data`=0, `err`=0.
- `stall` is combinational: (`mem_read`|`mem_w`) & legal & state≠DONE, forced 0 while `srst_n`=0.
- Zero-wait bus, request in IDLE at cycle T:
  - Store: REQ at T+1, DONE at T+2. `stall` high for T and T+1.
  - Load: REQ at T+1, WAIT at T+2 (rvalid), DONE at T+3. `stall` high for T through T+2.
- Each wait cycle on `gnt` or `rvalid` adds one stall cycle.
- Illegal request: `stall`=0 in cycle T; `err` is high at T+1 only.
- Reset mid-access: `bus_req` is low from the next edge. No transaction completes, and no `err` is raised.

## Structure
- Shared package `riscv_pkg`:
  - `lsu_state_e` enum.
  - `funct3` localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - Bus width constants.
- Sub-module `load_align`: combinational lane select plus sign/zero-extend, taking `bus_rdata`, `addr[1:0]` and `funct3`.
- The top level holds the FSM, the timeout counter and the request registers.

## Test plan
- SW at `addr`=0x100, `write_data`=0xDEADBEEF, `gnt` on first REQ cycle → `bus_addr`=0x100, `bus_be`=1111, `bus_we`=1, `stall` high exactly 2 cycles.
- LB at `addr`=0x103, `bus_rdata`=0x80FF_0000, `rvalid` one cycle after `gnt` → `read_data`=0xFFFFFF80 in DONE. Repeat as LBU → 0x00000080.
- SH at `addr`=0x102, `write_data`=0x1234ABCD → `bus_be`=1100, `bus_wdata`=0xABCDABCD. `gnt` delayed 3 cycles → fields stable throughout, `stall` high 5 cycles.
- LW at `addr`=0x101 → no `bus_req`, `stall` never high, `err` high for one cycle only.
- LW with `gnt` given but `rvalid` withheld 20 cycles, `TIMEOUT_CYC`=16 → `err` pulse, `read_data`=0, FSM back in IDLE. A late `rvalid` changes nothing.
- `srst_n` low during WAIT → `bus_req` and `read_data` are 0 next cycle, state IDLE. A following LHU at 0x200 with `bus_rdata`=0x0000_F00D → `read_data`=0x0000F00D.
